sext_accumulator: RTL and testbench



---
 rtl/sext_pkg.sv | 17 +
 rtl/sext_accumulator_sign_extend.sv | 20 ++
 rtl/sext_accumulator.sv | 104 ++++++++++
 tb/tb_sext_accumulator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sext_pkg.sv
// Shared definitions for the sample sign-extension and accumulation path.
package sext_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Replicate the sample MSB into the upper bits of the default-width word.
    function automatic logic [OUT_W_DEF-1:0] sext(input logic [IN_W_DEF-1:0] x);
        return {{(OUT_W_DEF-IN_W_DEF){x[IN_W_DEF-1]}}, x};
    endfunction

endpackage

// File: rtl/sext_accumulator_sign_extend.sv
// Combinational two's-complement widening stage, reusable on any signed bus.
module sign_extend
    import sext_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    generate
        if ((IN_W == IN_W_DEF) && (OUT_W == OUT_W_DEF)) begin : g_default
            assign dout = sext(din);
        end else begin : g_generic
            assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
        end
    endgenerate

endmodule

// File: rtl/sext_accumulator.sv
// Frame accumulator: sums N_SAMPLES sign-extended samples and hands the total
// to a 32-bit consumer over a valid/ready output.
module sext_accumulator
    import sext_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [OUT_W-1:0] acc_r;
    logic [OUT_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [OUT_W-1:0] sum_r;
    logic [OUT_W-1:0] sum_nxt_s;
    logic [OUT_W-1:0] sext_s;
    logic             hs_s;

    sign_extend #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sign_extend (
        .din  (in_data),
        .dout (sext_s)
    );

    // Handshakes depend only on the state flop, so no input-to-output comb path.
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == DONE);
    assign hs_s      = in_valid && (state_r == ACCUM);
    assign out_sum   = sum_r;
    assign out_cnt   = cnt_r;

    // Next-state and datapath update: accumulate until the last sample, then publish.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        sum_nxt_s   = sum_r;
        case (state_r)
            ACCUM: begin
                if (hs_s) begin
                    if (cnt_r == LAST_CNT) begin
                        sum_nxt_s   = acc_r + sext_s;
                        acc_nxt_s   = {OUT_W{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = DONE;
                    end else begin
                        acc_nxt_s   = acc_r + sext_s;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
                acc_nxt_s   = {OUT_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, accumulator, counter and result registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r <= ACCUM;
            acc_r   <= {OUT_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {OUT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sum_r   <= sum_nxt_s;
        end
    end

endmodule

// File: tb/tb_sext_accumulator.sv
// Self-checking bench for sext_accumulator: directed frames plus random traffic
// compared against a queue-based frame model.
module tb_sext_accumulator;

    localparam int N = 4;

    logic        clk;
    logic        areset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_cnt;

    logic        n1_in_valid;
    logic        n1_in_ready;
    logic [7:0]  n1_in_data;
    logic        n1_out_valid;
    logic        n1_out_ready;
    logic [31:0] n1_out_sum;
    logic [0:0]  n1_out_cnt;

    int          err_cnt;
    int          chk_cnt;

    byte         q[$];
    bit          m_pending;
    logic [31:0] m_sum;

    sext_accumulator #(.N_SAMPLES(N)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt)
    );

    sext_accumulator #(.N_SAMPLES(1)) dut_n1 (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (n1_in_valid),
        .in_ready  (n1_in_ready),
        .in_data   (n1_in_data),
        .out_valid (n1_out_valid),
        .out_ready (n1_out_ready),
        .out_sum   (n1_out_sum),
        .out_cnt   (n1_out_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the frame rules, compare at negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (!m_pending) begin
            if (v) begin
                q.push_back(byte'(d));
                if (q.size() == N) begin
                    s = 0;
                    foreach (q[i]) s += int'(q[i]);
                    m_sum     = 32'(s);
                    m_pending = 1'b1;
                    q.delete();
                end
            end
        end else if (r) begin
            m_pending = 1'b0;
        end
        @(negedge clk);
        check("in_ready",  32'(in_ready),  32'(!m_pending));
        check("out_valid", 32'(out_valid), 32'(m_pending));
        check("out_sum",   out_sum,        m_sum);
        check("out_cnt",   32'(out_cnt),   32'(q.size()));
    endtask

    // Assert reset between clock edges, check reset outputs, release on a negedge.
    task automatic do_reset();
        areset_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   out_sum,        32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        check("rst_n1_sum",    n1_out_sum,     32'd0);
        q.delete();
        m_pending = 1'b0;
        m_sum     = 32'd0;
        @(negedge clk);
        areset_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        clk          = 1'b0;
        areset_n     = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        out_ready    = 1'b0;
        n1_in_valid  = 1'b0;
        n1_in_data   = 8'h00;
        n1_out_ready = 1'b0;
        err_cnt      = 0;
        chk_cnt      = 0;
        m_pending    = 1'b0;
        m_sum        = 32'd0;
        #1;
        do_reset();

        // Mixed signs, back-to-back.
        step(1'b1, 8'h05, 1'b1);
        step(1'b1, 8'hFD, 1'b1);
        step(1'b1, 8'h7F, 1'b1);
        step(1'b1, 8'h80, 1'b1);
        check("mixed_valid", 32'(out_valid), 32'd1);
        check("mixed_sum",   out_sum,        32'h0000_0001);
        step(1'b0, 8'h00, 1'b1);

        // All negative.
        for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
        check("neg_ff_sum", out_sum, 32'hFFFF_FFFC);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h80, 1'b0);
        check("neg_80_sum", out_sum, 32'hFFFF_FE00);

        // Backpressure: still in DONE from the previous frame, upstream presents 0x11.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h11, 1'b0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum",      out_sum,       32'hFFFF_FE00);
        end
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h11, 1'b0);
        check("bp_first_cnt", 32'(out_cnt), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0);
        check("bp_frame_sum", out_sum, 32'h0000_0044);
        step(1'b0, 8'h00, 1'b1);

        // Input gaps of two idle cycles between samples.
        for (int i = 1; i <= 4; i++) begin
            check("gap_cnt", 32'(out_cnt), 32'(i - 1));
            step(1'b1, 8'(i), 1'b0);
            if (i < 4) begin
                step(1'b0, 8'hAA, 1'b0);
                step(1'b0, 8'h55, 1'b0);
            end
        end
        check("gap_sum", out_sum, 32'h0000_000A);
        step(1'b0, 8'h00, 1'b1);

        // Mid-frame reset discards partial sum.
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        in_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 1'b0);
        check("rst_frame_sum", out_sum, 32'h0000_0004);
        step(1'b0, 8'h00, 1'b1);

        // Single-sample frames on the N_SAMPLES=1 instance.
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        n1_in_valid  = 1'b1;
        n1_in_data   = 8'h80;
        n1_out_ready = 1'b1;
        @(negedge clk);
        check("n1_valid_a", 32'(n1_out_valid), 32'd1);
        check("n1_sum_a",   n1_out_sum,        32'hFFFF_FF80);
        check("n1_ready_a", 32'(n1_in_ready),  32'd0);
        n1_in_data = 8'h7F;
        @(negedge clk);
        check("n1_bubble",  32'(n1_out_valid), 32'd0);
        check("n1_ready_b", 32'(n1_in_ready),  32'd1);
        @(negedge clk);
        check("n1_valid_b", 32'(n1_out_valid), 32'd1);
        check("n1_sum_b",   n1_out_sum,        32'h0000_007F);
        n1_in_valid = 1'b0;
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) < 3));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
